// File: rtl/feature_pkg.sv
// Shared constants and state encoding for the feature-extraction frame sequencer.
//   FRAME_LEN : stored samples per frame (25 ms at 16 kHz)
//   NFFT      : FFT length, power of two; frames are zero-padded up to it
//   IDX_W     : width of a point index, log2(NFFT)
//   CNT_W     : width of the frame / overrun statistics counters
//   NBINS     : power bins returned per frame (NFFT/2+1)
package feature_pkg;

   localparam int FRAME_LEN = 400;
   localparam int NFFT      = 512;
   localparam int IDX_W     = 9;
   localparam int CNT_W     = 16;
   localparam int NBINS     = NFFT/2 + 1;
   localparam int BIN_W     = $clog2(NBINS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_FFT = 2'd2
   } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : increment request
//   count    : current value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
      end else if (inc && (count_r != '1)) begin
         count_r <= count_r + 1'b1;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/feature_frame_sequencer.sv
// Frame sequencer: streams one stored frame from the ping-pong buffer into the
// window / power-spectrum chain, zero-pads it to NFFT points, then waits for
// all NBINS power bins before accepting the next frame.
//   clk, rst        : fast clock, asynchronous active-high reset
//   frame_ready     : pulse, a full frame sits in bank frame_bank
//   fft_s_tready    : downstream takes the point issued this cycle
//   pow_tvalid      : one power bin returned this cycle
//   buf_rd_en/addr  : frame-buffer read strobe and {bank, index} address
//   sample_*        : point stream, one cycle behind the read (matches RAM latency)
//   pad_zero        : point lies beyond FRAME_LEN, downstream feeds 0.0
//   frame_done      : pulse after the last bin of a frame
//   busy            : not idle
//   frame_cnt       : frames completed (saturating)
//   overrun_cnt     : frames dropped because one was in flight (saturating)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for frame_ready
// ISSUE    | issuing points 0..NFFT-1, one per cycle with fft_s_tready
// WAIT_FFT | counting returned power bins until NBINS have arrived
module feature_frame_sequencer
   import feature_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_ready,
   input  logic             frame_bank,
   input  logic             fft_s_tready,
   input  logic             pow_tvalid,
   output logic             buf_rd_en,
   output logic [IDX_W:0]   buf_rd_addr,
   output logic             pad_zero,
   output logic             sample_tvalid,
   output logic [IDX_W-1:0] sample_idx,
   output logic             sample_tlast,
   output logic             frame_done,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] overrun_cnt
);

   // One extra bit so the compare also holds when FRAME_LEN equals NFFT.
   localparam logic [IDX_W:0]   FRAME_LEN_X = (IDX_W+1)'(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NFFT-1);
   localparam logic [BIN_W-1:0] LAST_BIN    = BIN_W'(NBINS-1);

   seq_state_t       state;
   logic             bank_r;
   logic [IDX_W-1:0] idx;
   logic [BIN_W-1:0] bin_cnt;

   logic issue;
   logic in_frame;
   logic last_point;
   logic bins_done;
   logic overrun_hit;

   assign issue       = (state == ISSUE) && fft_s_tready;
   assign in_frame    = ({1'b0, idx} < FRAME_LEN_X);
   assign last_point  = (idx == LAST_IDX);
   assign bins_done   = (state == WAIT_FFT) && pow_tvalid && (bin_cnt == LAST_BIN);
   assign overrun_hit = frame_ready && (state != IDLE);

   // The read strobe is tied to the issue cycle so the RAM data lines up with
   // the registered sample_* outputs one cycle later.
   assign buf_rd_en   = issue && in_frame;
   assign buf_rd_addr = buf_rd_en ? {bank_r, idx} : '0;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bank_r        <= 1'b0;
         idx           <= '0;
         bin_cnt       <= '0;
         sample_tvalid <= 1'b0;
         sample_idx    <= '0;
         pad_zero      <= 1'b0;
         sample_tlast  <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         sample_tvalid <= issue;
         sample_idx    <= issue ? idx : '0;
         pad_zero      <= issue && !in_frame;
         sample_tlast  <= issue && last_point;
         frame_done    <= bins_done;

         case (state)
            IDLE: begin
               if (frame_ready) begin
                  bank_r <= frame_bank;
                  idx    <= '0;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (fft_s_tready) begin
                  if (last_point) begin
                     bin_cnt <= '0;
                     state   <= WAIT_FFT;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            WAIT_FFT: begin
               if (pow_tvalid) begin
                  if (bin_cnt == LAST_BIN) begin
                     state <= IDLE;
                  end else begin
                     bin_cnt <= bin_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_frame_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bins_done),
      .count (frame_cnt)
   );

   sat_counter #(.W(CNT_W)) u_overrun_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (overrun_hit),
      .count (overrun_cnt)
   );

endmodule

// File: tb/tb_feature_frame_sequencer.sv
// Self-checking bench for feature_frame_sequencer.
module tb_feature_frame_sequencer;
   import feature_pkg::*;

   localparam int L  = 400;
   localparam int N  = 512;
   localparam int NB = 257;
   localparam int CMAX = 65535;

   logic             clk = 1'b0;
   logic             rst;
   logic             frame_ready;
   logic             frame_bank;
   logic             fft_s_tready;
   logic             pow_tvalid;
   logic             buf_rd_en;
   logic [IDX_W:0]   buf_rd_addr;
   logic             pad_zero;
   logic             sample_tvalid;
   logic [IDX_W-1:0] sample_idx;
   logic             sample_tlast;
   logic             frame_done;
   logic             busy;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] overrun_cnt;

   feature_frame_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .frame_ready   (frame_ready),
      .frame_bank    (frame_bank),
      .fft_s_tready  (fft_s_tready),
      .pow_tvalid    (pow_tvalid),
      .buf_rd_en     (buf_rd_en),
      .buf_rd_addr   (buf_rd_addr),
      .pad_zero      (pad_zero),
      .sample_tvalid (sample_tvalid),
      .sample_idx    (sample_idx),
      .sample_tlast  (sample_tlast),
      .frame_done    (frame_done),
      .busy          (busy),
      .frame_cnt     (frame_cnt),
      .overrun_cnt   (overrun_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: a frame is "points still to issue" then "bins still to come".
   int m_busy, m_bank, pts_left, bins_left;
   int m_tv, m_idx, m_pad, m_last, m_done;
   int m_frames, m_ovr;

   // Observations gathered from the DUT per section.
   int n_reads, n_points, n_done, first_addr, first_seen, tlast_cyc;

   typedef struct {
      int bank;
      int tr_pct;
      int pv_pct;
      int inject;
      int exp_first;
      int exp_reads;
      int exp_points;
      int exp_ovr;
   } vec_t;

   vec_t vecs[6];

   function automatic void chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_bank = 0; pts_left = 0; bins_left = 0;
      m_tv = 0; m_idx = 0; m_pad = 0; m_last = 0; m_done = 0;
      m_frames = 0; m_ovr = 0;
   endtask

   task automatic clr_obs();
      n_reads = 0; n_points = 0; n_done = 0; first_addr = -1; first_seen = 0; tlast_cyc = -1;
   endtask

   // One clock: apply inputs, check against the model mid-cycle, advance model.
   task automatic cycle(input bit fr, input bit bk, input bit tr, input bit pv);
      int cur, e_rd, b0;
      frame_ready  = fr;
      frame_bank   = bk;
      fft_s_tready = tr;
      pow_tvalid   = pv;
      cur  = N - pts_left;
      e_rd = (m_busy != 0 && pts_left > 0 && tr && cur < L) ? 1 : 0;
      @(negedge clk);
      chk("busy", int'(busy), m_busy);
      chk("buf_rd_en", int'(buf_rd_en), e_rd);
      if (e_rd != 0) chk("buf_rd_addr", int'(buf_rd_addr), m_bank * N + cur);
      chk("sample_tvalid", int'(sample_tvalid), m_tv);
      if (m_tv != 0) begin
         chk("sample_idx", int'(sample_idx), m_idx);
         chk("pad_zero", int'(pad_zero), m_pad);
         chk("sample_tlast", int'(sample_tlast), m_last);
      end
      chk("frame_done", int'(frame_done), m_done);
      chk("frame_cnt", int'(frame_cnt), m_frames);
      chk("overrun_cnt", int'(overrun_cnt), m_ovr);
      if (buf_rd_en) begin
         n_reads++;
         if (first_seen == 0) begin
            first_addr = int'(buf_rd_addr);
            first_seen = 1;
         end
      end
      if (sample_tvalid) n_points++;
      if (sample_tvalid && sample_tlast) tlast_cyc = cyc;
      if (frame_done) n_done++;
      @(posedge clk);
      b0 = m_busy;
      m_tv = 0; m_pad = 0; m_last = 0;
      m_done = (b0 != 0 && pts_left == 0 && pv && bins_left == 1) ? 1 : 0;
      if (fr && b0 != 0) m_ovr = sat(m_ovr + 1);
      if (b0 != 0 && pts_left > 0 && tr) begin
         m_tv = 1; m_idx = cur;
         m_pad = (cur >= L) ? 1 : 0;
         m_last = (cur == N - 1) ? 1 : 0;
         pts_left--;
         if (pts_left == 0) bins_left = NB;
      end else if (b0 != 0 && pts_left == 0 && pv) begin
         bins_left--;
         if (bins_left == 0) begin
            m_busy = 0;
            m_frames = sat(m_frames + 1);
         end
      end
      if (fr && b0 == 0) begin
         m_busy = 1; m_bank = int'(bk); pts_left = N;
      end
      cyc++;
      #1;
   endtask

   task automatic rnd_cycle(input bit fr, input bit bk, input int tr_pct, input int pv_pct);
      bit tr, pv;
      tr = (int'($urandom_range(99)) < tr_pct);
      pv = (int'($urandom_range(99)) < pv_pct);
      cycle(fr, bk, tr, pv);
   endtask

   task automatic finish_frame(input int tr_pct, input int pv_pct);
      int b;
      b = 0;
      while (m_busy != 0 && b < 20000) begin
         rnd_cycle(1'b0, 1'b0, tr_pct, pv_pct);
         b++;
      end
      if (m_busy != 0) chk("frame_timeout", 1, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fr_cyc, ovr0, frm0, inj_at, b;
      vecs[0] = '{0, 100, 100, 0,   0, 400, 512, 0};
      vecs[1] = '{1,  50,  50, 0, 512, 400, 512, 0};
      vecs[2] = '{1,  30,  80, 1, 512, 400, 512, 1};
      vecs[3] = '{0,  70,  20, 1,   0, 400, 512, 1};
      vecs[4] = '{1, 100, 100, 1, 512, 400, 512, 1};
      vecs[5] = '{0,  90,  40, 0,   0, 400, 512, 0};

      rst = 1'b1; frame_ready = 1'b0; frame_bank = 1'b0;
      fft_s_tready = 1'b0; pow_tvalid = 1'b0;
      model_reset();
      clr_obs();

      // Reset state, before any clock edge.
      #3;
      chk("rst_buf_rd_en", int'(buf_rd_en), 0);
      chk("rst_buf_rd_addr", int'(buf_rd_addr), 0);
      chk("rst_sample_tvalid", int'(sample_tvalid), 0);
      chk("rst_sample_idx", int'(sample_idx), 0);
      chk("rst_pad_zero", int'(pad_zero), 0);
      chk("rst_sample_tlast", int'(sample_tlast), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      chk("rst_overrun_cnt", int'(overrun_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cycle(1'b0, 1'b0, 1'b1, 1'b1);

      // Single frame, tready held high, bank 0.
      clr_obs();
      fr_cyc = cyc;
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (520) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("h1_tlast_latency", tlast_cyc - fr_cyc, 513);
      chk("h1_reads", n_reads, 400);
      chk("h1_first_addr", first_addr, 0);
      chk("h1_points", n_points, 512);
      chk("h1_no_done_yet", n_done, 0);
      repeat (257) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("h1_done_pulses", n_done, 1);
      chk("h1_frame_cnt", int'(frame_cnt), 1);

      // frame_ready (bank 1) during WAIT_FFT is an overrun and issues nothing.
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (512) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      clr_obs();
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("h2_overrun_cnt", int'(overrun_cnt), 1);
      chk("h2_no_reads", n_reads, 0);
      repeat (257) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      clr_obs();
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("h2_bank1_first_addr", first_addr, 512);

      // frame_ready in the same cycle as frame_done starts a new frame.
      b = 0;
      while (pts_left > 0 && b < 1000) begin cycle(1'b0, 1'b0, 1'b1, 1'b0); b++; end
      b = 0;
      while (m_done == 0 && b < 1000) begin cycle(1'b0, 1'b0, 1'b0, 1'b1); b++; end
      chk("h3_reached_done", m_done, 1);
      clr_obs();
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      chk("h3_done_seen", n_done, 1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("h3_overrun_unchanged", int'(overrun_cnt), 1);
      chk("h3_busy", int'(busy), 1);
      chk("h3_new_reads", n_reads, 1);
      finish_frame(100, 100);

      // Reset at idx 200 aborts the frame asynchronously.
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (200) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk("h4_buf_rd_en", int'(buf_rd_en), 0);
      chk("h4_buf_rd_addr", int'(buf_rd_addr), 0);
      chk("h4_sample_tvalid", int'(sample_tvalid), 0);
      chk("h4_sample_idx", int'(sample_idx), 0);
      chk("h4_pad_zero", int'(pad_zero), 0);
      chk("h4_sample_tlast", int'(sample_tlast), 0);
      chk("h4_frame_done", int'(frame_done), 0);
      chk("h4_busy", int'(busy), 0);
      chk("h4_frame_cnt", int'(frame_cnt), 0);
      chk("h4_overrun_cnt", int'(overrun_cnt), 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      clr_obs();
      repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      chk("h4_no_done_after_rst", n_done, 0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      finish_frame(100, 100);
      chk("h4_fresh_done", n_done, 1);
      chk("h4_fresh_frame_cnt", int'(frame_cnt), 1);
      chk("h4_fresh_points", n_points, 512);

      // Randomised scenarios from the vector table.
      for (int i = 0; i < 6; i++) begin
         clr_obs();
         ovr0 = int'(overrun_cnt);
         frm0 = int'(frame_cnt);
         inj_at = int'($urandom_range(400, 1));
         cycle(1'b1, vecs[i].bank[0], 1'b0, 1'b0);
         b = 0;
         while (m_busy != 0 && b < 20000) begin
            rnd_cycle((vecs[i].inject != 0) && (b == inj_at), $urandom_range(1, 0) != 0,
                      vecs[i].tr_pct, vecs[i].pv_pct);
            b++;
         end
         if (m_busy != 0) chk("vec_timeout", 1, 0);
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         chk("vec_reads", n_reads, vecs[i].exp_reads);
         chk("vec_points", n_points, vecs[i].exp_points);
         chk("vec_first_addr", first_addr, vecs[i].exp_first);
         chk("vec_done", n_done, 1);
         chk("vec_overrun_delta", int'(overrun_cnt) - ovr0, vecs[i].exp_ovr);
         chk("vec_frame_delta", int'(frame_cnt) - frm0, 1);
      end

      // Saturation of both counters.
      force dut.u_frame_cnt.count_r = 16'hFFFE;
      force dut.u_overrun_cnt.count_r = 16'hFFFE;
      #1;
      release dut.u_frame_cnt.count_r;
      release dut.u_overrun_cnt.count_r;
      m_frames = 16'hFFFE;
      m_ovr = 16'hFFFE;
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      chk("sat_overrun_max", int'(overrun_cnt), 16'hFFFF);
      finish_frame(100, 100);
      chk("sat_frame_max", int'(frame_cnt), 16'hFFFF);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      finish_frame(80, 80);
      chk("sat_overrun_hold", int'(overrun_cnt), 16'hFFFF);
      chk("sat_frame_hold", int'(frame_cnt), 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
